// File: rtl/iob_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// iob_wb_rr_arbiter
//
// Round-robin arbiter that lets N_REQ IOb requesters share one IOb manager
// port.  It is placed in front of the IOb-to-Wishbone converter so several
// cores can reach a single Wishbone subordinate.  Only one transaction is
// ever outstanding toward the converter; a read keeps ownership of the port
// until its read data comes back.
//
// Parameters
//   N_REQ   number of requester ports (2..8)
//   ADDR_W  address width, common to all ports
//   DATA_W  data width; strobe width is DATA_W/8
//
// Ports
//   clk_i       clock
//   cke_i       clock enable; 0 freezes all state
//   arst_i      synchronous active-high reset, overrides cke_i
//   s_valid_i   per-requester request valid
//   s_addr_i    per-requester address, requester k uses slice k
//   s_wdata_i   per-requester write data, slice k
//   s_wstrb_i   per-requester write strobes, slice k; all-zero means read
//   s_ready_o   per-requester accept, only the owner can see it
//   s_rvalid_o  per-requester read data valid, only the owner can see it
//   s_rdata_o   read data broadcast to all requesters
//   m_valid_o   request valid toward the converter (registered)
//   m_addr_o    address toward the converter (registered owner copy)
//   m_wdata_o   write data toward the converter (registered owner copy)
//   m_wstrb_o   strobes toward the converter (registered owner copy)
//   m_ready_i   converter accepted the request
//   m_rvalid_i  converter read data valid
//   m_rdata_i   converter read data
//   grant_o     one-hot current owner, 0 when idle
// ---------------------------------------------------------------------------
module iob_wb_rr_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk_i,
    input  logic                          cke_i,
    input  logic                          arst_i,
    input  logic [N_REQ-1:0]              s_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]       s_addr_i,
    input  logic [N_REQ*DATA_W-1:0]       s_wdata_i,
    input  logic [N_REQ*(DATA_W/8)-1:0]   s_wstrb_i,
    output logic [N_REQ-1:0]              s_ready_o,
    output logic [N_REQ-1:0]              s_rvalid_o,
    output logic [DATA_W-1:0]             s_rdata_o,
    output logic                          m_valid_o,
    output logic [ADDR_W-1:0]             m_addr_o,
    output logic [DATA_W-1:0]             m_wdata_o,
    output logic [DATA_W/8-1:0]           m_wstrb_o,
    input  logic                          m_ready_i,
    input  logic                          m_rvalid_i,
    input  logic [DATA_W-1:0]             m_rdata_i,
    output logic [N_REQ-1:0]              grant_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    // Registered state and its next-state copies
    state_t              state_q,    state_d;
    logic [PTR_W-1:0]    prio_ptr_q, prio_ptr_d;
    logic [PTR_W-1:0]    owner_q,    owner_d;
    logic [N_REQ-1:0]    grant_q,    grant_d;
    logic                m_valid_q,  m_valid_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [STRB_W-1:0]   wstrb_q,    wstrb_d;

    // Arbitration result for the current cycle
    logic                pick_found_s;
    logic [PTR_W-1:0]    pick_idx_s;
    logic [N_REQ-1:0]    pick_onehot_s;
    logic [ADDR_W-1:0]   pick_addr_s;
    logic [DATA_W-1:0]   pick_wdata_s;
    logic [STRB_W-1:0]   pick_wstrb_s;

    // Handshake pass-through qualifiers
    logic                is_read_s;
    logic                ready_pass_s;
    logic                rvalid_pass_s;

    // Pointer increment with an explicit wrap, so non-power-of-2 N_REQ
    // never produces an index past the last requester.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(N_REQ - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Round-robin search: first valid requester at or after prio_ptr_q
    always_comb begin
        logic [PTR_W-1:0] cand;
        pick_found_s = 1'b0;
        pick_idx_s   = prio_ptr_q;
        cand         = prio_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found_s && s_valid_i[cand]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand;
            end else begin
                pick_found_s = pick_found_s;
            end
            cand = ptr_inc(cand);
        end
    end

    // Select the winner's payload and one-hot grant using constant slices
    always_comb begin
        pick_onehot_s = {N_REQ{1'b0}};
        pick_addr_s   = {ADDR_W{1'b0}};
        pick_wdata_s  = {DATA_W{1'b0}};
        pick_wstrb_s  = {STRB_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx_s == PTR_W'(k)) begin
                pick_onehot_s[k] = 1'b1;
                pick_addr_s      = s_addr_i[k*ADDR_W +: ADDR_W];
                pick_wdata_s     = s_wdata_i[k*DATA_W +: DATA_W];
                pick_wstrb_s     = s_wstrb_i[k*STRB_W +: STRB_W];
            end else begin
                pick_onehot_s[k] = 1'b0;
            end
        end
    end

    assign is_read_s = (wstrb_q == {STRB_W{1'b0}});

    // Ready/rvalid pass-throughs; frozen clock or pending reset masks them
    // so a stale handshake can never reach a requester.
    always_comb begin
        ready_pass_s  = 1'b0;
        rvalid_pass_s = 1'b0;
        if (cke_i && !arst_i) begin
            ready_pass_s  = (state_q == ST_ISSUE) && m_ready_i;
            // A zero-latency read returns data in the accept cycle itself.
            rvalid_pass_s = m_rvalid_i &&
                            ((state_q == ST_WAIT_RD) ||
                             ((state_q == ST_ISSUE) && m_ready_i && is_read_s));
        end else begin
            ready_pass_s  = 1'b0;
            rvalid_pass_s = 1'b0;
        end
    end

    // Next-state logic for the arbitration FSM and its registered outputs
    always_comb begin
        state_d    = state_q;
        prio_ptr_d = prio_ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        m_valid_d  = m_valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d   = ST_ISSUE;
                    owner_d   = pick_idx_s;
                    grant_d   = pick_onehot_s;
                    m_valid_d = 1'b1;
                    addr_d    = pick_addr_s;
                    wdata_d   = pick_wdata_s;
                    wstrb_d   = pick_wstrb_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    if (!is_read_s || m_rvalid_i) begin
                        // Write accepted, or read answered in the same cycle
                        state_d    = ST_IDLE;
                        grant_d    = {N_REQ{1'b0}};
                        prio_ptr_d = ptr_inc(owner_q);
                    end else begin
                        state_d = ST_WAIT_RD;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_RD: begin
                if (m_rvalid_i) begin
                    state_d    = ST_IDLE;
                    grant_d    = {N_REQ{1'b0}};
                    prio_ptr_d = ptr_inc(owner_q);
                end else begin
                    state_d = ST_WAIT_RD;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = {N_REQ{1'b0}};
                m_valid_d = 1'b0;
            end
        endcase
    end

    // FSM register: synchronous reset wins over the clock enable
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q    <= ST_IDLE;
            prio_ptr_q <= {PTR_W{1'b0}};
            owner_q    <= {PTR_W{1'b0}};
            grant_q    <= {N_REQ{1'b0}};
            m_valid_q  <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            wstrb_q    <= {STRB_W{1'b0}};
        end else if (cke_i) begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            m_valid_q  <= m_valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end else begin
            state_q    <= state_q;
            prio_ptr_q <= prio_ptr_q;
            owner_q    <= owner_q;
            grant_q    <= grant_q;
            m_valid_q  <= m_valid_q;
            addr_q     <= addr_q;
            wdata_q    <= wdata_q;
            wstrb_q    <= wstrb_q;
        end
    end

    assign m_valid_o  = m_valid_q;
    assign m_addr_o   = addr_q;
    assign m_wdata_o  = wdata_q;
    assign m_wstrb_o  = wstrb_q;
    assign grant_o    = grant_q;
    assign s_ready_o  = ready_pass_s  ? grant_q : {N_REQ{1'b0}};
    assign s_rvalid_o = rvalid_pass_s ? grant_q : {N_REQ{1'b0}};
    assign s_rdata_o  = m_rdata_i;

endmodule

// File: tb/tb_iob_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iob_wb_rr_arbiter
// Self-checking bench for iob_wb_rr_arbiter with three requesters, so the
// round-robin wrap is exercised on a non-power-of-2 count.
// ---------------------------------------------------------------------------
module tb_iob_wb_rr_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic                       clk = 1'b0;
    logic                       cke;
    logic                       arst;
    logic [N_REQ-1:0]           s_valid;
    logic [N_REQ*ADDR_W-1:0]    s_addr;
    logic [N_REQ*DATA_W-1:0]    s_wdata;
    logic [N_REQ*STRB_W-1:0]    s_wstrb;
    logic [N_REQ-1:0]           s_ready;
    logic [N_REQ-1:0]           s_rvalid;
    logic [DATA_W-1:0]          s_rdata;
    logic                       m_valid_o;
    logic [ADDR_W-1:0]          m_addr_o;
    logic [DATA_W-1:0]          m_wdata_o;
    logic [STRB_W-1:0]          m_wstrb_o;
    logic                       m_ready;
    logic                       m_rvalid;
    logic [DATA_W-1:0]          m_rdata;
    logic [N_REQ-1:0]           grant;

    logic [ADDR_W-1:0]          req_addr  [N_REQ];
    logic [DATA_W-1:0]          req_wdata [N_REQ];
    logic [STRB_W-1:0]          req_wstrb [N_REQ];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign s_addr [g*ADDR_W +: ADDR_W] = req_addr[g];
        assign s_wdata[g*DATA_W +: DATA_W] = req_wdata[g];
        assign s_wstrb[g*STRB_W +: STRB_W] = req_wstrb[g];
    end

    iob_wb_rr_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i      (clk),
        .cke_i      (cke),
        .arst_i     (arst),
        .s_valid_i  (s_valid),
        .s_addr_i   (s_addr),
        .s_wdata_i  (s_wdata),
        .s_wstrb_i  (s_wstrb),
        .s_ready_o  (s_ready),
        .s_rvalid_o (s_rvalid),
        .s_rdata_o  (s_rdata),
        .m_valid_o  (m_valid_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_wstrb_o  (m_wstrb_o),
        .m_ready_i  (m_ready),
        .m_rvalid_i (m_rvalid),
        .m_rdata_i  (m_rdata),
        .grant_o    (grant)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Apply control inputs just after the active edge
    task automatic drive(input logic rst, input logic ck, input logic [N_REQ-1:0] v,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        arst = rst; cke = ck; s_valid = v; m_ready = rdy; m_rvalid = rv; m_rdata = rd;
    endtask

    // Compare the handshake-level outputs at the falling edge
    task automatic expect_out(input string tag, input logic mv, input logic [N_REQ-1:0] g,
                              input logic [N_REQ-1:0] rdy, input logic [N_REQ-1:0] rv);
        @(negedge clk);
        check({tag, "_m_valid"}, 64'(m_valid_o), 64'(mv));
        check({tag, "_grant"},   64'(grant),     64'(g));
        check({tag, "_s_ready"}, 64'(s_ready),   64'(rdy));
        check({tag, "_s_rvalid"},64'(s_rvalid),  64'(rv));
    endtask

    typedef struct {
        logic        rst, ck;
        logic [2:0]  v;
        logic [31:0] a0;  logic [3:0] w0;
        logic [31:0] a1;  logic [3:0] w1;
        logic        mr, mrv;
        logic [31:0] rd;
        logic        mv;
        logic [2:0]  g, rdy, rv;
        logic [31:0] ma;  logic [3:0] mw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [2:0] v,
                                input logic [31:0] a0, input logic [3:0] w0,
                                input logic [31:0] a1, input logic [3:0] w1,
                                input logic mr, input logic mrv, input logic [31:0] rd,
                                input logic mv, input logic [2:0] g, input logic [2:0] rdy,
                                input logic [2:0] rv, input logic [31:0] ma, input logic [3:0] mw);
        vec_t r;
        r.rst = rst; r.ck = 1'b1; r.v = v; r.a0 = a0; r.w0 = w0; r.a1 = a1; r.w1 = w1;
        r.mr = mr; r.mrv = mrv; r.rd = rd; r.mv = mv; r.g = g; r.rdy = rdy; r.rv = rv;
        r.ma = ma; r.mw = mw;
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int k);
        logic [N_REQ-1:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    // Round robin from the spec rules: first requester after the last one served
    function automatic int rr_pick(input int last, input logic [N_REQ-1:0] v);
        int r;
        int k;
        r = -1;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (last + i) % N_REQ;
            if (r < 0 && v[k]) r = k;
        end
        return r;
    endfunction

    // Random-phase state: requester agents, downstream, reference model
    logic              ag_pend [N_REQ];
    logic              dn_rd_pend;
    int                dn_cnt;
    int                lat;
    logic              mdl_busy, mdl_rd_out, mdl_is_read;
    int                mdl_owner, mdl_last;
    logic [ADDR_W-1:0] mdl_addr;
    logic [DATA_W-1:0] mdl_wdata;
    logic [STRB_W-1:0] mdl_wstrb;
    logic              exp_mv;
    logic [N_REQ-1:0]  exp_g, exp_rdy, exp_rv;

    initial begin
        arst = 1'b1; cke = 1'b1; s_valid = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_addr[k] = 32'h0000_0030; req_wdata[k] = 32'hA000_0000 + 32'(k); req_wstrb[k] = 4'hF;
        end
        repeat (2) @(posedge clk);

        // ---------------- table-driven directed vectors ----------------
        //             rst  v       a0        w0    a1        w1    mr    mrv   rdata          mv    g       rdy     rv      maddr     mws
        vecs.push_back(mk(1'b1, 3'b000, 32'h0,   4'h0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h10,  4'hF, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h10,  4'hF, 32'h0,   4'h0, 1'b1, 1'b0, 32'h0,         1'b1, 3'b001, 3'b001, 3'b000, 32'h10,  4'hF));
        vecs.push_back(mk(1'b0, 3'b000, 32'h10,  4'hF, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0,   4'h0, 32'h20,  4'h0, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0,   4'h0, 32'h20,  4'h0, 1'b1, 1'b0, 32'h0,         1'b1, 3'b010, 3'b010, 3'b000, 32'h20,  4'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0,   4'h0, 32'h20,  4'h0, 1'b0, 1'b0, 32'h0,         1'b0, 3'b010, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0,   4'h0, 32'h20,  4'h0, 1'b1, 1'b0, 32'h0,         1'b0, 3'b010, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0,   4'h0, 32'h20,  4'h0, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 3'b010, 3'b000, 3'b010, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0,   4'h0, 32'h20,  4'h0, 1'b1, 1'b1, 32'h11111111,  1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));
        // contention: both write continuously, grants must alternate 0,1,0,1
        for (int j = 0; j < 4; j++) begin
            vecs.push_back(mk(1'b0, 3'b011, 32'h100, 4'hF, 32'h104, 4'hF, 1'b1, 1'b0, 32'h0,     1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));
            vecs.push_back(mk(1'b0, 3'b011, 32'h100, 4'hF, 32'h104, 4'hF, 1'b1, 1'b0, 32'h0,     1'b1, onehot(j % 2), onehot(j % 2), 3'b000,
                              (j % 2 == 0) ? 32'h100 : 32'h104, 4'hF));
        end
        // read blocking: requester 0 read outstanding while requester 1 writes
        vecs.push_back(mk(1'b0, 3'b001, 32'h40,  4'h0, 32'h104, 4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b011, 32'h40,  4'h0, 32'h44,  4'hF, 1'b1, 1'b0, 32'h0,         1'b1, 3'b001, 3'b001, 3'b000, 32'h40,  4'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h40,  4'h0, 32'h44,  4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 3'b001, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h40,  4'h0, 32'h44,  4'hF, 1'b1, 1'b0, 32'h0,         1'b0, 3'b001, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h40,  4'h0, 32'h44,  4'hF, 1'b0, 1'b1, 32'h12345678,  1'b0, 3'b001, 3'b000, 3'b001, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h40,  4'h0, 32'h44,  4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h40,  4'h0, 32'h44,  4'hF, 1'b1, 1'b0, 32'h0,         1'b1, 3'b010, 3'b010, 3'b000, 32'h44,  4'hF));
        vecs.push_back(mk(1'b0, 3'b000, 32'h40,  4'h0, 32'h44,  4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 3'b000, 32'h0,   4'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ck, vecs[i].v, vecs[i].mr, vecs[i].mrv, vecs[i].rd);
            req_addr[0] = vecs[i].a0; req_wstrb[0] = vecs[i].w0;
            req_addr[1] = vecs[i].a1; req_wstrb[1] = vecs[i].w1;
            expect_out($sformatf("vec%0d", i), vecs[i].mv, vecs[i].g, vecs[i].rdy, vecs[i].rv);
            if (vecs[i].mv) begin
                check($sformatf("vec%0d_m_addr", i),  64'(m_addr_o),  64'(vecs[i].ma));
                check($sformatf("vec%0d_m_wstrb", i), 64'(m_wstrb_o), 64'(vecs[i].mw));
            end
            if (vecs[i].rv != 3'b000) begin
                check($sformatf("vec%0d_s_rdata", i), 64'(s_rdata), 64'(vecs[i].rd));
            end
        end

        // ---------------- clock enable low for 3 cycles in ISSUE ----------------
        req_addr[2] = 32'h30; req_wstrb[2] = 4'hF;
        drive(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 32'h0);
        expect_out("cke_pre", 1'b0, 3'b000, 3'b000, 3'b000);
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 32'h0);
            expect_out($sformatf("cke_hold%0d", j), 1'b1, 3'b100, 3'b000, 3'b000);
            check($sformatf("cke_hold%0d_m_addr", j), 64'(m_addr_o), 64'h30);
        end
        drive(1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 32'h0);
        expect_out("cke_resume", 1'b1, 3'b100, 3'b100, 3'b000);
        // owner 2 was last, pointer wraps to 0
        req_wstrb[0] = 4'hF; req_wstrb[1] = 4'hF;
        drive(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 32'h0);
        expect_out("wrap_idle", 1'b0, 3'b000, 3'b000, 3'b000);
        drive(1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 32'h0);
        expect_out("wrap_grant", 1'b1, 3'b001, 3'b001, 3'b000);
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
        expect_out("wrap_done", 1'b0, 3'b000, 3'b000, 3'b000);

        // ---------------- reset while waiting for read data ----------------
        req_addr[0] = 32'h50; req_wstrb[0] = 4'h0;
        drive(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 32'h0);
        expect_out("rst_idle", 1'b0, 3'b000, 3'b000, 3'b000);
        drive(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 32'h0);
        expect_out("rst_issue", 1'b1, 3'b001, 3'b001, 3'b000);
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
        expect_out("rst_wait", 1'b0, 3'b001, 3'b000, 3'b000);
        drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 32'hBAD0BAD0);
        expect_out("rst_late_rvalid", 1'b0, 3'b000, 3'b000, 3'b000);
        // pointer back at 0 after reset
        req_wstrb[0] = 4'hF; req_wstrb[1] = 4'hF;
        drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 32'h0);
        expect_out("rst_arb", 1'b0, 3'b000, 3'b000, 3'b000);
        drive(1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 32'h0);
        expect_out("rst_ptr", 1'b1, 3'b001, 3'b001, 3'b000);

        // ---------------- zero-latency read ----------------
        req_addr[1] = 32'h60; req_wstrb[1] = 4'h0;
        drive(1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 32'h0);
        expect_out("zl_idle", 1'b0, 3'b000, 3'b000, 3'b000);
        drive(1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 32'hCAFEF00D);
        expect_out("zl_fwd", 1'b1, 3'b010, 3'b010, 3'b010);
        check("zl_rdata", 64'(s_rdata), 64'hCAFEF00D);
        drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0);
        expect_out("zl_done", 1'b0, 3'b000, 3'b000, 3'b000);

        // ---------------- randomized run against the reference model ----------------
        drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < N_REQ; k++) ag_pend[k] = 1'b0;
        dn_rd_pend = 1'b0; dn_cnt = 0;
        mdl_busy = 1'b0; mdl_rd_out = 1'b0; mdl_is_read = 1'b0;
        mdl_owner = -1; mdl_last = N_REQ - 1;
        mdl_addr = '0; mdl_wdata = '0; mdl_wstrb = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            #1;
            arst = 1'b0; cke = 1'b1;
            for (int k = 0; k < N_REQ; k++) begin
                if (!ag_pend[k] && $urandom_range(0, 2) == 0) begin
                    ag_pend[k]   = 1'b1;
                    req_addr[k]  = $urandom;
                    req_wdata[k] = $urandom;
                    req_wstrb[k] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                end
                s_valid[k] = ag_pend[k];
            end
            m_ready  = 1'($urandom_range(0, 1));
            m_rdata  = $urandom;
            m_rvalid = 1'b0;
            if (dn_rd_pend) begin
                dn_cnt--;
                if (dn_cnt == 0) begin
                    m_rvalid = 1'b1; dn_rd_pend = 1'b0;
                end
            end else if (m_valid_o && m_ready && (m_wstrb_o == 4'h0)) begin
                lat = $urandom_range(0, 4);
                if (lat == 0) m_rvalid = 1'b1;
                else begin
                    dn_rd_pend = 1'b1; dn_cnt = lat;
                end
            end else if (!m_valid_o && ($urandom_range(0, 7) == 0)) begin
                m_rvalid = 1'b1;
            end

            @(negedge clk);
            exp_g   = mdl_busy ? onehot(mdl_owner) : '0;
            exp_mv  = mdl_busy && !mdl_rd_out;
            exp_rdy = (exp_mv && m_ready) ? exp_g : '0;
            exp_rv  = (mdl_busy && m_rvalid && (mdl_rd_out || (m_ready && mdl_is_read))) ? exp_g : '0;
            check($sformatf("rnd%0d_m_valid", cyc), 64'(m_valid_o), 64'(exp_mv));
            check($sformatf("rnd%0d_grant", cyc),   64'(grant),     64'(exp_g));
            check($sformatf("rnd%0d_s_ready", cyc), 64'(s_ready),   64'(exp_rdy));
            check($sformatf("rnd%0d_s_rvalid", cyc),64'(s_rvalid),  64'(exp_rv));
            if (exp_mv) begin
                check($sformatf("rnd%0d_m_addr", cyc),  64'(m_addr_o),  64'(mdl_addr));
                check($sformatf("rnd%0d_m_wdata", cyc), 64'(m_wdata_o), 64'(mdl_wdata));
                check($sformatf("rnd%0d_m_wstrb", cyc), 64'(m_wstrb_o), 64'(mdl_wstrb));
            end
            if (exp_rv != '0) begin
                check($sformatf("rnd%0d_s_rdata", cyc), 64'(s_rdata), 64'(m_rdata));
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (exp_rdy[k]) ag_pend[k] = 1'b0;
            end
            if (mdl_busy) begin
                if (!mdl_rd_out) begin
                    if (m_ready) begin
                        if (!mdl_is_read || m_rvalid) begin
                            mdl_busy = 1'b0; mdl_last = mdl_owner; mdl_owner = -1;
                        end else begin
                            mdl_rd_out = 1'b1;
                        end
                    end
                end else if (m_rvalid) begin
                    mdl_busy = 1'b0; mdl_rd_out = 1'b0; mdl_last = mdl_owner; mdl_owner = -1;
                end
            end else if (s_valid != '0) begin
                mdl_owner   = rr_pick(mdl_last, s_valid);
                mdl_busy    = 1'b1;
                mdl_rd_out  = 1'b0;
                mdl_addr    = req_addr[mdl_owner];
                mdl_wdata   = req_wdata[mdl_owner];
                mdl_wstrb   = req_wstrb[mdl_owner];
                mdl_is_read = (req_wstrb[mdl_owner] == 4'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
